// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART register loader.
// Optional even parity: define UART_REG_LOADER_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef enum logic {
        WAIT_CMD,
        WAIT_DATA
    } ld_state_t;

    localparam int CMD_FLAG_BIT = 7;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Synchronizer, 8-bit UART byte receiver and parity check.
// Parity bit present only when UART_REG_LOADER_PARITY_EN is defined.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic rx_s1, rx_s2, rx_d;
    logic fall;

    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shift, shift_n;
    logic stop_hold, hold_n;
    logic [7:0] byte_n;
    logic valid_n, ferr_n;

    // rx_d lets the edge detector compare consecutive synchronized samples
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall = rx_d & ~rx_s2;

`ifdef UART_REG_LOADER_PARITY_EN
    logic par_bad, par_bad_n;
    logic perr_n;
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad      <= par_bad_n;
            parity_err_q <= perr_n;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            stop_hold <= 1'b0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            stop_hold <= hold_n;
            rx_byte   <= byte_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        hold_n  = stop_hold;
        byte_n  = rx_byte;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_REG_LOADER_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall) begin
                    state_n = START;
                    bit_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    state_n = rx_s2 ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    shift_n = {rx_s2, shift[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_REG_LOADER_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef UART_REG_LOADER_PARITY_EN
            PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    par_bad_n = rx_s2 ^ (^shift);
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (stop_hold) begin
                    // bad stop bit: wait for the line to idle before rearming
                    if (rx_s2) begin
                        hold_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else if (cnt == FULL_M1) begin
                    cnt_n = '0;
`ifdef UART_REG_LOADER_PARITY_EN
                    perr_n = par_bad;
                    if (rx_s2) begin
                        state_n = IDLE;
                        if (!par_bad) begin
                            byte_n  = shift;
                            valid_n = 1'b1;
                        end
                    end else begin
                        ferr_n = 1'b1;
                        hold_n = 1'b1;
                    end
`else
                    if (rx_s2) begin
                        state_n = IDLE;
                        byte_n  = shift;
                        valid_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                        hold_n = 1'b1;
                    end
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_reg_loader.sv
// UART command loader: {addr byte, data byte} -> register-file write.
// Optional even parity: define UART_REG_LOADER_PARITY_EN.
module uart_reg_loader
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       we3,
    output logic [2:0] wa3,
    output logic [7:0] wd3,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       cmd_err
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int TMO = TIMEOUT_BITS * CPB;
    localparam int TW  = $clog2(TMO);
    localparam logic [TW-1:0] TMO_M1 = TW'(TMO - 1);

    ld_state_t ld, ld_n;
    logic [TW-1:0] tmo, tmo_n;
    logic we_n, ce_n;
    logic [2:0] wa_n;
    logic [7:0] wd_n;

    uart_rx_core #(
        .CLKS_PER_BIT(CPB)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ld      <= WAIT_CMD;
            tmo     <= '0;
            we3     <= 1'b0;
            wa3     <= '0;
            wd3     <= '0;
            cmd_err <= 1'b0;
        end else begin
            ld      <= ld_n;
            tmo     <= tmo_n;
            we3     <= we_n;
            wa3     <= wa_n;
            wd3     <= wd_n;
            cmd_err <= ce_n;
        end
    end

    always_comb begin
        ld_n  = ld;
        tmo_n = tmo;
        we_n  = 1'b0;
        ce_n  = 1'b0;
        wa_n  = wa3;
        wd_n  = wd3;
        unique case (ld)
            WAIT_CMD: begin
                tmo_n = '0;
                if (rx_valid) begin
                    if (rx_byte[CMD_FLAG_BIT]) begin
                        wa_n = rx_byte[2:0];
                        ld_n = WAIT_DATA;
                    end else begin
                        ce_n = 1'b1;
                    end
                end
            end
            WAIT_DATA: begin
                // an arriving byte outranks an expiring timeout
                if (rx_valid) begin
                    wd_n = rx_byte;
                    we_n = 1'b1;
                    ld_n = WAIT_CMD;
                end else if (frame_err || parity_err) begin
                    ld_n = WAIT_CMD;
                end else if (tmo == TMO_M1) begin
                    ce_n = 1'b1;
                    ld_n = WAIT_CMD;
                end else begin
                    tmo_n = tmo + TW'(1);
                end
            end
            default: begin
                ld_n = WAIT_CMD;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_reg_loader.sv
// Directed bench for uart_reg_loader at 10 clocks per bit.
module tb_uart_reg_loader;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_we = 0, n_ce = 0, n_rv = 0, n_fe = 0, n_pe = 0;
    int ce_cyc = 0, rv_cyc = 0;

    typedef struct {
        int             n;
        logic [2:0][7:0] b;
        int             we;
        int             ce;
        int             rv;
        logic [2:0]     wa;
        logic [7:0]     wd;
        logic [7:0]     last;
    } vec_t;

    vec_t vecs [5];

    uart_reg_loader #(
        .CLK_HZ      (1_000_000),
        .BAUD        (100_000),
        .TIMEOUT_BITS(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (we3) n_we++;
        if (cmd_err) begin
            n_ce++;
            ce_cyc = cyc;
        end
        if (rx_valid) begin
            n_rv++;
            rv_cyc = cyc;
        end
        if (frame_err) n_fe++;
        if (parity_err) n_pe++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop_v,
                            input logic par_flip);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_REG_LOADER_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk);
`else
        if (par_flip) rx = ~rx;
`endif
        rx = stop_v;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b, 1'b1, 1'b0);
    endtask

    function automatic vec_t mk(input int n, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2,
                                input int we, input int ce, input int rv,
                                input logic [2:0] wa, input logic [7:0] wd,
                                input logic [7:0] last);
        vec_t v;
        v.n = n;
        v.b = {b2, b1, b0};
        v.we = we;
        v.ce = ce;
        v.rv = rv;
        v.wa = wa;
        v.wd = wd;
        v.last = last;
        return v;
    endfunction

    initial begin
        int we0, ce0, rv0, fe0, pe0;
        int waited;
        vecs[0] = mk(2, 8'h83, 8'h5A, 8'h00, 1, 0, 2, 3'd3, 8'h5A, 8'h5A);
        vecs[1] = mk(3, 8'h12, 8'h81, 8'hFF, 1, 1, 3, 3'd1, 8'hFF, 8'hFF);
        vecs[2] = mk(2, 8'hF8, 8'h00, 8'h00, 1, 0, 2, 3'd0, 8'h00, 8'h00);
        vecs[3] = mk(2, 8'h8F, 8'h80, 8'h00, 1, 0, 2, 3'd7, 8'h80, 8'h80);
        vecs[4] = mk(1, 8'h7F, 8'h00, 8'h00, 0, 1, 1, 3'd7, 8'h80, 8'h7F);

        rst = 1'b1;
        rx  = 1'b1;
        settle(5);
        chk("rst_we3", int'(we3), 0);
        chk("rst_wa3", int'(wa3), 0);
        chk("rst_wd3", int'(wd3), 0);
        chk("rst_rx_byte", int'(rx_byte), 0);
        chk("rst_flags", int'({rx_valid, frame_err, parity_err, cmd_err}), 0);
        rst = 1'b0;
        settle(10);

        foreach (vecs[i]) begin
            we0 = n_we; ce0 = n_ce; rv0 = n_rv; fe0 = n_fe; pe0 = n_pe;
            for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
            settle(30);
            chk($sformatf("v%0d_we", i), n_we - we0, vecs[i].we);
            chk($sformatf("v%0d_cmd_err", i), n_ce - ce0, vecs[i].ce);
            chk($sformatf("v%0d_rx_valid", i), n_rv - rv0, vecs[i].rv);
            chk($sformatf("v%0d_errs", i), (n_fe - fe0) + (n_pe - pe0), 0);
            chk($sformatf("v%0d_wa3", i), int'(wa3), int'(vecs[i].wa));
            chk($sformatf("v%0d_wd3", i), int'(wd3), int'(vecs[i].wd));
            chk($sformatf("v%0d_rx_byte", i), int'(rx_byte), int'(vecs[i].last));
        end

        // short glitch must be ignored
        we0 = n_we; ce0 = n_ce; rv0 = n_rv; fe0 = n_fe;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        settle(40);
        chk("glitch_rx_valid", n_rv - rv0, 0);
        chk("glitch_errs", (n_fe - fe0) + (n_ce - ce0), 0);
        send_byte(8'h83);
        send_byte(8'h11);
        settle(30);
        chk("glitch_after_we", n_we - we0, 1);
        chk("glitch_after_wd3", int'(wd3), 8'h11);

        // bad stop bit on the data byte
        we0 = n_we; ce0 = n_ce; rv0 = n_rv; fe0 = n_fe;
        send_byte(8'h84);
        send_raw(8'h3C, 1'b0, 1'b0);
        settle(30);
        chk("frame_fe", n_fe - fe0, 1);
        chk("frame_we", n_we - we0, 0);
        chk("frame_rv", n_rv - rv0, 1);
        chk("frame_ce", n_ce - ce0, 0);
        chk("frame_wa3", int'(wa3), 4);
        send_byte(8'h22);
        settle(30);
        chk("frame_then_cmd_err", n_ce - ce0, 1);
        chk("frame_then_we", n_we - we0, 0);

        // data byte timeout
        we0 = n_we; ce0 = n_ce;
        send_byte(8'h85);
        waited = 0;
        while (n_ce == ce0 && waited < 500) begin
            settle(1);
            waited++;
        end
        chk("tmo_fired", n_ce - ce0, 1);
        checks++;
        if ((ce_cyc - rv_cyc) < 318 || (ce_cyc - rv_cyc) > 324) begin
            errors++;
            $display("FAIL tmo_delay: got %0d cycles expected 318..324",
                     ce_cyc - rv_cyc);
        end
        settle(400 - waited > 0 ? 400 - waited : 1);
        chk("tmo_we", n_we - we0, 0);
        chk("tmo_wa3", int'(wa3), 5);
        send_byte(8'h77);
        settle(30);
        chk("tmo_then_reject", n_ce - ce0, 2);
        chk("tmo_then_we", n_we - we0, 0);

        // reset in bit 4 of a data byte
        send_byte(8'h86);
        settle(5);
        chk("pre_rst_wa3", int'(wa3), 6);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        settle(1);
        chk("midrst_wa3", int'(wa3), 0);
        chk("midrst_wd3", int'(wd3), 0);
        chk("midrst_rx_byte", int'(rx_byte), 0);
        chk("midrst_flags",
            int'({we3, rx_valid, frame_err, parity_err, cmd_err}), 0);
        rx = 1'b1;
        settle(5);
        rst = 1'b0;
        settle(20);
        we0 = n_we;
        send_byte(8'h82);
        send_byte(8'h01);
        settle(30);
        chk("post_rst_we", n_we - we0, 1);
        chk("post_rst_wa3", int'(wa3), 2);
        chk("post_rst_wd3", int'(wd3), 1);

`ifdef UART_REG_LOADER_PARITY_EN
        rv0 = n_rv; pe0 = n_pe; fe0 = n_fe;
        send_raw(8'h07, 1'b1, 1'b1);
        settle(30);
        chk("par_pe", n_pe - pe0, 1);
        chk("par_rv", n_rv - rv0, 0);
        chk("par_fe", n_fe - fe0, 0);
`else
        chk("no_parity_err", n_pe, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
